sync_fifo_ext: RTL and testbench
================================

// Module: sync_fifo_ext
// PURPOSE
//  Parametrised single-clock FIFO. It is the next-generation replacement for the basic synchronous FIFO.
//  Adds the following:
//   - programmable almost_full/almost_empty thresholds
//   - occupancy count output
//   - sticky overflow/underflow error flags with clear
//   - optional first-word-fall-through (FWFT) read mode
//  Sits between a producer and a consumer in the same clock domain; driven by the layered bench via intf.
// PARAMETERS
//  DATA_WIDTH  8        width of each data word
//  DEPTH       8        number of entries; power of 2, >=2
//  AF_LEVEL    DEPTH-1  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    1        almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//  FWFT        0        0 = registered read (1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk           in   1                 clock, rising edge
//  rst_n         in   1                 asynchronous active-low reset
//  w_en          in   1                 write request
//  r_en          in   1                 read request (pop)
//  data_in       in   DATA_WIDTH        write data
//  clr_err       in   1                 clears overflow/underflow
//  data_out      out  DATA_WIDTH        read data
//  full          out  1                 count == DEPTH
//  empty         out  1                 count == 0
//  almost_full   out  1                 count >= AF_LEVEL
//  almost_empty  out  1                 count <= AE_LEVEL
//  count         out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  overflow      out  1                 sticky: write attempted while full
//  underflow     out  1                 sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst_n=0, takes effect immediately, no clock needed):
//     - pointers = 0, count = 0, data_out = 0, overflow = 0, underflow = 0
//     - empty = 1, almost_empty = 1, full = 0, almost_full = 0
//     - contents are discarded
//  - Reset mid-operation: all stored words are lost; the first write after rst_n rises is read first.
//  - Accept rules use the registered state at the clock edge:
//     - write accepted iff w_en && !full
//     - read accepted iff r_en && !empty
//  - Simultaneous accepted read+write: count unchanged, both pointers advance.
//  - Full with w_en && r_en: the read is accepted and the write is rejected.
//     - count becomes DEPTH-1; overflow sets.
//  - Empty with w_en && r_en: the write is accepted and the read is rejected.
//     - count becomes 1; underflow sets.
//  - Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
//     - count is the separate register that disambiguates full from empty.
//  - All flags are combinational decodes of the registered count, so they change on the same edge as count.
//  - overflow/underflow error flags:
//     - each sets on the edge where its rejected request occurs, then stays set
//     - cleared by clr_err=1 at an edge
//     - if set and clear coincide, set wins
//  - FWFT=0:
//     - data_out registers mem[rd_ptr] on the edge of an accepted read (1-cycle latency)
//     - otherwise holds its value; a rejected read leaves it unchanged
//  - FWFT=1:
//     - data_out = mem[rd_ptr] whenever empty=0
//     - a word written into an empty FIFO appears on data_out after that write edge
//     - r_en pops it; the next word is visible after the pop edge
//     - data_out is don't-care while empty=1
//  - Parameter legality: DEPTH not a power of 2, or AF_LEVEL/AE_LEVEL out of range -> $error at elaboration.
// TESTING
//  1. Fill (DEPTH=8, AF_LEVEL=7): reset, write 0x01..0x08 on consecutive cycles
//     -> almost_full=1 at count=7; full=1 and count=8 after the 8th write; almost_empty=0 from count=2.
//  2. Overflow then drain: 9th write 0xFF while full -> overflow=1, count stays 8.
//     Then read 8 times (FWFT=0) -> data_out 0x01..0x08, one cycle after each r_en.
//     0xFF never appears; empty=1 at end.
//  3. Underflow and clear: r_en while empty -> underflow=1, count=0, data_out unchanged.
//     Pulse clr_err -> overflow=0 and underflow=0.
//  4. Simultaneous operations:
//     - w_en & r_en at count=3 -> count stays 3, FIFO order preserved
//     - w_en & r_en at full -> count=7, overflow=1
//  5. Wrap-around and reset: 40 random interleaved write/read ops, scoreboard matches every word.
//     Then assert rst_n=0 mid-clock at count=5 -> count=0, empty=1 before the next edge.
//  6. FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 after that edge with no r_en.
//     Write 0x5A, pulse r_en -> data_out=0x5A next cycle.

Source files
------------

// File: rtl/sync_fifo_ext_if.sv
// rtl/sync_fifo_ext_if.sv - producer/consumer handshake bundle for sync_fifo_ext
interface sync_fifo_ext_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic                     w_en;
    logic                     r_en;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     clr_err;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    // Side that pushes/pops and observes status.
    modport master (
        output w_en, r_en, data_in, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  w_en, r_en, data_in, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - single-clock FIFO with thresholds, occupancy, sticky errors and optional FWFT
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter bit FWFT       = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    sync_fifo_ext_if.slave intf
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // Reject illegal configurations while elaborating rather than building a broken FIFO.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_ext: DEPTH must be a power of 2 and >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo_ext: AF_LEVEL must be in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_ext: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_w;
    logic                  empty_w;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags are pure decodes of the registered count so they move on the same edge as count.
    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);

    // Acceptance looks only at registered state: a full FIFO can still take a read,
    // an empty FIFO can still take a write, in the same cycle.
    assign wr_acc = intf.w_en && !full_w;
    assign rd_acc = intf.r_en && !empty_w;

    assign intf.full         = full_w;
    assign intf.empty        = empty_w;
    assign intf.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign intf.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign intf.count        = count_q;
    assign intf.overflow     = overflow_q;
    assign intf.underflow    = underflow_q;

    // Pointers wrap naturally at DEPTH; count carries the extra bit that separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are never reset, the pointers/count make stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= intf.data_in;
        end
    end

    // Sticky error flags: a rejected request sets, clr_err clears, set has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (intf.w_en && full_w) begin
                overflow_q <= 1'b1;
            end else if (intf.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (intf.r_en && empty_w) begin
                underflow_q <= 1'b1;
            end else if (intf.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is presented combinationally; forced to zero while empty so nothing stale leaks out.
        assign intf.data_out = empty_w ? '0 : mem[rd_ptr];
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] data_q;

        // Registered read: capture the head word only on an accepted pop, hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= mem[rd_ptr];
            end
        end

        assign intf.data_out = data_q;
    end
endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - self-checking bench for sync_fifo_ext (registered and FWFT instances)
module tb_sync_fifo_ext;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 7;
    localparam int AE    = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ext_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) intf_reg ();
    sync_fifo_ext_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) intf_ft ();

    sync_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .intf  (intf_reg)
    );

    sync_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_ft (
        .clk   (clk),
        .rst_n (rst_n),
        .intf  (intf_ft)
    );

    typedef struct {
        logic       w;
        logic       r;
        logic       clr;
        logic [7:0] din;
        int         cnt;
        logic       ovf;
        logic       unf;
        logic [7:0] dout;
    } vec_t;

    vec_t       vecs[$];
    int         tests = 0;
    int         fails = 0;

    // Reference model: a queue of stored words plus the sticky flags and last popped word.
    logic [7:0] mq[$];
    logic       m_ovf  = 1'b0;
    logic       m_unf  = 1'b0;
    logic [7:0] m_dout = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic ovf, input logic unf,
                               input logic [7:0] dout);
        check({tag, ".count"}, 32'(intf_reg.count), 32'(cnt));
        check({tag, ".full"}, 32'(intf_reg.full), 32'(cnt == DEPTH));
        check({tag, ".empty"}, 32'(intf_reg.empty), 32'(cnt == 0));
        check({tag, ".almost_full"}, 32'(intf_reg.almost_full), 32'(cnt >= AF));
        check({tag, ".almost_empty"}, 32'(intf_reg.almost_empty), 32'(cnt <= AE));
        check({tag, ".overflow"}, 32'(intf_reg.overflow), 32'(ovf));
        check({tag, ".underflow"}, 32'(intf_reg.underflow), 32'(unf));
        check({tag, ".data_out"}, 32'(intf_reg.data_out), 32'(dout));
    endtask

    task automatic check_model(input string tag);
        check_state(tag, mq.size(), m_ovf, m_unf, m_dout);
    endtask

    task automatic add(input logic w, input logic r, input logic clr, input logic [7:0] din,
                       input int cnt, input logic ovf, input logic unf, input logic [7:0] dout);
        vec_t v;
        v.w = w; v.r = r; v.clr = clr; v.din = din;
        v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.dout = dout;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = 8'h00;
    endtask

    // One clock on the registered FIFO, mirrored in the model; returns 1 ns after the edge.
    task automatic cycle(input logic w, input logic r, input logic clr, input logic [7:0] din);
        logic wa;
        logic ra;
        intf_reg.w_en    = w;
        intf_reg.r_en    = r;
        intf_reg.clr_err = clr;
        intf_reg.data_in = din;
        wa = w && (mq.size() < DEPTH);
        ra = r && (mq.size() != 0);
        if (w && mq.size() == DEPTH) m_ovf = 1'b1;
        else if (clr)                m_ovf = 1'b0;
        if (r && mq.size() == 0)     m_unf = 1'b1;
        else if (clr)                m_unf = 1'b0;
        if (ra) m_dout = mq.pop_front();
        if (wa) mq.push_back(din);
        @(posedge clk);
        #1;
        intf_reg.w_en    = 1'b0;
        intf_reg.r_en    = 1'b0;
        intf_reg.clr_err = 1'b0;
    endtask

    task automatic ft_cycle(input logic w, input logic r, input logic [7:0] din);
        intf_ft.w_en    = w;
        intf_ft.r_en    = r;
        intf_ft.data_in = din;
        @(posedge clk);
        #1;
        intf_ft.w_en = 1'b0;
        intf_ft.r_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] word;
        int         guard;

        intf_reg.w_en = 1'b0; intf_reg.r_en = 1'b0; intf_reg.clr_err = 1'b0; intf_reg.data_in = '0;
        intf_ft.w_en  = 1'b0; intf_ft.r_en  = 1'b0; intf_ft.clr_err  = 1'b0; intf_ft.data_in  = '0;

        // Reset state
        #12;
        check_model("reset");
        check("reset.ft_empty", 32'(intf_ft.empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill 0x01..0x08
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, 1'b0, 8'(k), k, 1'b0, 1'b0, 8'h00);
        // Overflow write, then drain
        add(1'b1, 1'b0, 1'b0, 8'hFF, 8, 1'b1, 1'b0, 8'h00);
        for (int j = 1; j <= 8; j++) add(1'b0, 1'b1, 1'b0, 8'h00, 8 - j, 1'b1, 1'b0, 8'(j));
        // Underflow, then clear
        add(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 8'h08);
        add(1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h08);
        // Simultaneous read+write at count 3 and at full
        add(1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h08);
        add(1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h08);
        add(1'b1, 1'b0, 1'b0, 8'h33, 3, 1'b0, 1'b0, 8'h08);
        add(1'b1, 1'b1, 1'b0, 8'h44, 3, 1'b0, 1'b0, 8'h11);
        for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 1'b0, 8'(8'h55 + k * 8'h11), 4 + k, 1'b0, 1'b0, 8'h11);
        add(1'b1, 1'b1, 1'b0, 8'hAA, 7, 1'b1, 1'b0, 8'h22);
        for (int k = 0; k < 7; k++) add(1'b0, 1'b1, 1'b0, 8'h00, 6 - k, 1'b1, 1'b0, 8'(8'h33 + k * 8'h11));
        add(1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h99);

        foreach (vecs[i]) begin
            cycle(vecs[i].w, vecs[i].r, vecs[i].clr, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].unf, vecs[i].dout);
        end

        // Random interleaved traffic against the queue model
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  8'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        // Bring occupancy to 5, then reset between edges
        guard = 0;
        while (mq.size() != 5 && guard < 20) begin
            if (mq.size() < 5) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
            else               cycle(1'b0, 1'b1, 1'b0, 8'h00);
            guard++;
        end
        check("pre_reset.count", 32'(intf_reg.count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset.count", 32'(intf_reg.count), 32'd0);
        check("async_reset.empty", 32'(intf_reg.empty), 32'd1);
        model_reset();
        check_model("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        cycle(1'b1, 1'b0, 1'b0, 8'hC3);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        word = intf_reg.data_out;
        check("post_reset.first_word", 32'(word), 32'h3C);
        check_model("post_reset");

        // FWFT instance
        ft_cycle(1'b1, 1'b0, 8'hA5);
        check("fwft.first_visible", 32'(intf_ft.data_out), 32'hA5);
        check("fwft.count1", 32'(intf_ft.count), 32'd1);
        check("fwft.not_empty", 32'(intf_ft.empty), 32'd0);
        ft_cycle(1'b1, 1'b0, 8'h5A);
        check("fwft.head_held", 32'(intf_ft.data_out), 32'hA5);
        check("fwft.count2", 32'(intf_ft.count), 32'd2);
        ft_cycle(1'b0, 1'b1, 8'h00);
        check("fwft.after_pop", 32'(intf_ft.data_out), 32'h5A);
        check("fwft.count_pop", 32'(intf_ft.count), 32'd1);
        ft_cycle(1'b0, 1'b1, 8'h00);
        check("fwft.empty", 32'(intf_ft.empty), 32'd1);
        ft_cycle(1'b0, 1'b1, 8'h00);
        check("fwft.underflow", 32'(intf_ft.underflow), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
